// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control bundles for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned JF_W  = 3;

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERR      = 2'd2;

    localparam int unsigned JF_J  = 0;
    localparam int unsigned JF_BR = 1;
    localparam int unsigned JF_JR = 2;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = S_RUN,
        ST_MEM_WAIT = S_MEM_WAIT,
        ST_ERR      = S_ERR
    } state_t;

    // Per-cycle pipeline control bundle
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_write;
        logic memwb_write;
        logic stall;
    } ctrl_t;

    localparam ctrl_t CTRL_PASS   = ctrl_t'(7'b1100110);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b0000001);
    localparam ctrl_t CTRL_FLUSH2 = ctrl_t'(7'b1111110);
    localparam ctrl_t CTRL_FLUSH1 = ctrl_t'(7'b1110110);
    localparam ctrl_t CTRL_LU     = ctrl_t'(7'b0001111);

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector between the ID and EX stages.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_rs_id,
    input  logic [REG_W-1:0] i_rt_id,
    input  logic             i_use_rs_id,
    input  logic             i_use_rt_id,
    input  logic             i_memread_ex,
    input  logic [REG_W-1:0] i_rd_ex,
    output logic             o_lu_c
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_use_rs_id & (i_rs_id == i_rd_ex);
    assign w_rt_hit = i_use_rt_id & (i_rt_id == i_rd_ex);

    // $zero is never a real producer, so a load into it cannot create a hazard
    assign o_lu_c = i_memread_ex & (i_rd_ex != REG_ZERO) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles,
// redirect flushes, data-memory wait freeze with timeout error latch.
// Optional perf counters (stall_cycles, flush_events) under PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             memread_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic [JF_W-1:0]  JumpFlag,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_write,
    output logic             Stall,
    output logic             mem_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lu;
    logic             w_mp;
    logic             w_frozen;
    ctrl_t            w_ctrl;

    hazard_detect u_hazard_detect (
        .i_rs_id      (rs_id),
        .i_rt_id      (rt_id),
        .i_use_rs_id  (use_rs_id),
        .i_use_rt_id  (use_rt_id),
        .i_memread_ex (memread_ex),
        .i_rd_ex      (rd_ex),
        .o_lu_c       (w_lu)
    );

    assign w_mp = mem_req & ~mem_ack;

    // Pipeline freezes on a fresh miss, an unfinished wait, or after a timeout
    always_comb begin
        w_frozen = 1'b1;
        case (r_state)
            ST_RUN:      w_frozen = w_mp;
            ST_MEM_WAIT: w_frozen = ~mem_ack;
            default:     w_frozen = 1'b1;
        endcase
    end

    // Output priority mux; an ack in MEM_WAIT falls through to the RUN rules
    always_comb begin
        w_ctrl = CTRL_PASS;
        if (!reset) begin
            w_ctrl = CTRL_PASS;
        end else if (w_frozen) begin
            w_ctrl = CTRL_FREEZE;
        end else if (JumpFlag[JF_BR] | JumpFlag[JF_JR]) begin
            w_ctrl = CTRL_FLUSH2;
        end else if (JumpFlag[JF_J]) begin
            w_ctrl = CTRL_FLUSH1;
        end else if (w_lu) begin
            w_ctrl = CTRL_LU;
        end
    end

    assign pc_write    = w_ctrl.pc_write;
    assign ifid_write  = w_ctrl.ifid_write;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_flush  = w_ctrl.idex_flush;
    assign exmem_write = w_ctrl.exmem_write;
    assign memwb_write = w_ctrl.memwb_write;
    assign Stall       = w_ctrl.stall;
    assign mem_err     = (r_state == ST_ERR);

    // State and timeout counter; counter holds the number of frozen cycles so far
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mp) begin
                        r_state <= ST_MEM_WAIT;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_ERR;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // Saturating stall-cycle and IF/ID flush counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_ctrl.stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_ctrl.ifid_flush && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule
